// File: rtl/bw_pack_pkg.sv
// Shared types and widths for the 1-bit pixel packer and its output FIFO.
package bw_pack_pkg;

  localparam int WORD_W = 16;
  localparam int PIX_W  = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/word_fifo.sv
// Small synchronous FIFO. A push into a full FIFO only succeeds when a pop
// happens in the same cycle; a pop from an empty FIFO is ignored.
module word_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bw_pack.sv
// Thresholds a grayscale pixel stream to 1 bit/pixel and packs 16 pixels per
// word (first pixel in bit 0) into an output FIFO; one frame per i_start.
// Output handshake: a word transfers on any rising edge where o_word_valid and
// i_word_ready are both high; o_word holds while valid is high and ready low.
module bw_pack
  import bw_pack_pkg::*;
#(
  parameter int IMG_W      = 640,
  parameter int IMG_H      = 480,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [PIX_W-1:0]  i_threshold,
  input  logic [PIX_W-1:0]  i_bw,
  input  logic              i_valid,
  output logic [WORD_W-1:0] o_word,
  output logic              o_word_valid,
  input  logic              i_word_ready,
  output logic              o_busy,
  output logic              o_frame_done,
  output logic              o_overflow,
  output logic [1:0]        o_state
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H + 1);

  state_t            state;
  state_t            state_next;
  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic [3:0]        bit_cnt;
  logic [WORD_W-1:0] shreg;
  logic [PIX_W-1:0]  thr;
  logic              overflow;

  logic              accept;
  logic              pix_bit;
  logic              word_done;
  logic              last_pix;
  logic [WORD_W-1:0] packed_word;
  logic              fifo_full;
  logic              fifo_empty;
  logic              drop;

  assign accept      = (state == RUN) && i_valid;
  assign pix_bit     = (i_bw >= thr);
  assign word_done   = accept && (bit_cnt == 4'd15);
  assign last_pix    = accept && (x == XW'(IMG_W - 1)) && (y == YW'(IMG_H - 1));
  // Shift right so the oldest pixel lands in bit 0 once 16 have arrived.
  assign packed_word = {pix_bit, shreg[WORD_W-1:1]};
  assign drop        = word_done && fifo_full && !i_word_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next   = state;
    o_frame_done = 1'b0;
    case (state)
      IDLE:    if (i_start) state_next = RUN;
      RUN:     if (last_pix) state_next = DRAIN;
      DRAIN: begin
        if (fifo_empty) begin
          state_next   = IDLE;
          o_frame_done = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      x        <= '0;
      y        <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      thr      <= '0;
      overflow <= 1'b0;
    end else if (state == IDLE && i_start) begin
      x        <= '0;
      y        <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      thr      <= i_threshold;
      overflow <= 1'b0;
    end else if (accept) begin
      shreg   <= packed_word;
      bit_cnt <= bit_cnt + 4'd1;
      if (x == XW'(IMG_W - 1)) begin
        x <= '0;
        y <= y + YW'(1);
      end else begin
        x <= x + XW'(1);
      end
      if (drop) overflow <= 1'b1;
    end
  end

  word_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (i_clk),
    .rst   (i_rst),
    .push  (word_done),
    .pop   (i_word_ready),
    .wdata (packed_word),
    .rdata (o_word),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign o_word_valid = !fifo_empty;
  assign o_busy       = (state == RUN) || (state == DRAIN);
  assign o_overflow   = overflow;
  assign o_state      = state;

endmodule

// File: tb/tb_bw_pack.sv
// Directed bench for bw_pack: a 32x2 instance with a word scoreboard and a
// 32x3 instance used for FIFO overflow and full push/pop cases.
module tb_bw_pack;

  logic        clk = 1'b0;
  logic        rst;
  logic        pstart;
  logic        pvalid;
  logic        sel3;
  logic [9:0]  thr;
  logic [9:0]  bw;
  logic        ready;
  logic        ready3;

  logic [15:0] word, word3;
  logic        wvalid, busy, done, ovf;
  logic        wvalid3, busy3, done3, ovf3;
  logic [1:0]  state, state3;

  int          total = 0;
  int          bad = 0;
  int          n_words = 0;
  int          n_done = 0;
  logic [15:0] exp_q[$];
  logic [15:0] w3tab [6];

  always #5 clk = ~clk;

  bw_pack #(.IMG_W(32), .IMG_H(2), .FIFO_DEPTH(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(pstart & ~sel3), .i_threshold(thr),
    .i_bw(bw), .i_valid(pvalid & ~sel3), .o_word(word), .o_word_valid(wvalid),
    .i_word_ready(ready), .o_busy(busy), .o_frame_done(done),
    .o_overflow(ovf), .o_state(state)
  );

  bw_pack #(.IMG_W(32), .IMG_H(3), .FIFO_DEPTH(4)) dut3 (
    .i_clk(clk), .i_rst(rst), .i_start(pstart & sel3), .i_threshold(thr),
    .i_bw(bw), .i_valid(pvalid & sel3), .o_word(word3), .o_word_valid(wvalid3),
    .i_word_ready(ready3), .o_busy(busy3), .o_frame_done(done3),
    .o_overflow(ovf3), .o_state(state3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input logic [9:0] t);
    thr    = t;
    pstart = 1'b1;
    tick();
    pstart = 1'b0;
    thr    = 10'd0;
  endtask

  task automatic send_pix(input logic [9:0] v);
    bw     = v;
    pvalid = 1'b1;
    tick();
    pvalid = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w, input int lo, input int hi, input bit model);
    for (int i = lo; i <= hi; i++) send_pix(w[i] ? 10'd700 : 10'd200);
    if (model && hi == 15) exp_q.push_back(w);
  endtask

  task automatic wait_idle(input bit use3);
    int n = 0;
    while ((use3 ? busy3 : busy) && n < 40) begin
      tick();
      n++;
    end
    check(use3 ? "idle3_timeout" : "idle_timeout", use3 ? busy3 : busy, 0);
  endtask

  // Scoreboard: every word transferred on the 32x2 instance is compared in order.
  always @(negedge clk) begin
    if (!rst && wvalid && ready) begin
      n_words++;
      if (exp_q.size() == 0) check("sb_extra_word", word, 16'hxxxx);
      else                   check("sb_word", word, exp_q.pop_front());
    end
    if (!rst && done) n_done++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, d0;
    w3tab = '{16'h1357, 16'h2468, 16'h9ABC, 16'hDEF0, 16'h0F0F, 16'hC3A5};
    rst = 1'b1; pstart = 1'b0; pvalid = 1'b0; sel3 = 1'b0;
    thr = '0; bw = '0; ready = 1'b1; ready3 = 1'b0;
    tick(); tick();
    check("rst_word", word, 0);
    check("rst_valid", wvalid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ovf", ovf, 0);
    check("rst_state", state, 0);
    rst = 1'b0;
    tick();

    // Threshold 512, threshold input changed after start must not matter.
    w0 = n_words; d0 = n_done;
    start_frame(10'd512);
    check("a_busy", busy, 1);
    exp_q.push_back(16'h5555);
    for (int i = 0; i < 16; i++) send_pix((i % 2 == 0) ? 10'd600 : 10'd100);
    check("a_lat_valid", wvalid, 1);
    check("a_lat_word", word, 16'h5555);
    exp_q.push_back(16'h0000);
    for (int i = 0; i < 16; i++) send_pix(10'd511);
    exp_q.push_back(16'hFFFF);
    for (int i = 0; i < 16; i++) send_pix(10'd512);
    exp_q.push_back(16'h00FF);
    for (int i = 0; i < 16; i++) send_pix((i < 8) ? 10'd1023 : 10'd0);
    wait_idle(0);
    check("a_words", n_words - w0, 4);
    check("a_done", n_done - d0, 1);
    check("a_queue", exp_q.size(), 0);

    // Threshold 300: equality gives 1, one below gives 0.
    w0 = n_words; d0 = n_done;
    start_frame(10'd300);
    exp_q.push_back(16'hFFFF);
    for (int i = 0; i < 16; i++) send_pix(10'd300);
    exp_q.push_back(16'h0000);
    for (int i = 0; i < 16; i++) send_pix(10'd299);
    exp_q.push_back(16'hAAAA);
    for (int i = 0; i < 16; i++) send_pix((i % 2 == 1) ? 10'd1023 : 10'd0);
    exp_q.push_back(16'h8001);
    for (int i = 0; i < 16; i++) send_pix((i == 0 || i == 15) ? 10'd300 : 10'd0);
    wait_idle(0);
    check("b_words", n_words - w0, 4);
    check("b_done", n_done - d0, 1);

    // Consumer stalled for the whole frame: exactly fills the FIFO.
    w0 = n_words; d0 = n_done;
    ready = 1'b0;
    start_frame(10'd512);
    send_word(16'h1234, 0, 15, 1);
    send_word(16'h5678, 0, 15, 1);
    send_word(16'hFEDC, 0, 15, 1);
    send_word(16'h0001, 0, 15, 1);
    check("c_ovf", ovf, 0);
    check("c_valid", wvalid, 1);
    check("c_state_drain", state, 2);
    tick(); tick();
    check("c_hold_word", word, 16'h1234);
    check("c_hold_busy", busy, 1);
    ready = 1'b1;
    wait_idle(0);
    check("c_words", n_words - w0, 4);
    check("c_done", n_done - d0, 1);

    // Six words into a four-entry FIFO with no consumer.
    sel3 = 1'b1;
    start_frame(10'd512);
    for (int k = 0; k < 4; k++) send_word(w3tab[k], 0, 15, 0);
    check("d_ovf_at4", ovf3, 0);
    send_word(w3tab[4], 0, 15, 0);
    check("d_ovf_at5", ovf3, 1);
    send_word(w3tab[5], 0, 15, 0);
    check("d_busy", busy3, 1);
    for (int k = 0; k < 4; k++) begin
      check("d_word", word3, w3tab[k]);
      ready3 = 1'b1;
      tick();
      ready3 = 1'b0;
    end
    check("d_done", done3, 1);
    tick();
    check("d_idle_state", state3, 0);
    check("d_empty", wvalid3, 0);
    check("d_ovf_sticky", ovf3, 1);

    // Push and pop in the same cycle while full: nothing lost.
    start_frame(10'd512);
    check("e_ovf_clear", ovf3, 0);
    for (int k = 0; k < 4; k++) send_word(w3tab[k], 0, 15, 0);
    send_word(w3tab[4], 0, 14, 0);
    ready3 = 1'b1;
    send_word(w3tab[4], 15, 15, 0);
    ready3 = 1'b0;
    check("e_ovf_pushpop", ovf3, 0);
    check("e_head", word3, w3tab[1]);
    send_word(w3tab[5], 0, 15, 0);
    check("e_ovf_drop", ovf3, 1);
    for (int k = 1; k < 5; k++) begin
      check("e_word", word3, w3tab[k]);
      ready3 = 1'b1;
      tick();
      ready3 = 1'b0;
    end
    wait_idle(1);
    sel3 = 1'b0;

    // Reset at pixel 20 with a word queued, then a clean frame.
    d0 = n_done;
    ready = 1'b0;
    start_frame(10'd512);
    send_word(16'hBEEF, 0, 15, 0);
    send_word(16'hFFFF, 0, 3, 0);
    check("f_pre_valid", wvalid, 1);
    #2;
    rst = 1'b1;
    #1;
    check("f_rst_valid", wvalid, 0);
    check("f_rst_word", word, 0);
    check("f_rst_busy", busy, 0);
    check("f_rst_state", state, 0);
    check("f_rst_ovf", ovf, 0);
    exp_q.delete();
    tick(); tick();
    rst = 1'b0;
    check("f_no_done", n_done - d0, 0);
    ready = 1'b1;
    w0 = n_words;
    start_frame(10'd512);
    send_word(16'h8421, 0, 15, 1);
    send_word(16'h0FF0, 0, 15, 1);
    send_word(16'h7E7E, 0, 15, 1);
    send_word(16'h4000, 0, 15, 1);
    wait_idle(0);
    check("f_words", n_words - w0, 4);
    check("f_done", n_done - d0, 1);

    // Pixels in IDLE ignored; a start mid-frame neither restarts nor re-latches.
    w0 = n_words; d0 = n_done;
    for (int i = 0; i < 5; i++) send_pix(10'd700);
    check("g_idle_valid", wvalid, 0);
    check("g_idle_words", n_words - w0, 0);
    start_frame(10'd512);
    send_word(16'h3C3C, 0, 15, 1);
    send_word(16'hA5A5, 0, 15, 1);
    exp_q.push_back(16'h0101);
    send_word(16'h0101, 0, 7, 0);
    pstart = 1'b1;
    thr    = 10'd5;
    send_pix(10'd700);
    pstart = 1'b0;
    thr    = 10'd0;
    send_word(16'h0101, 9, 15, 0);
    send_word(16'hFF00, 0, 15, 1);
    wait_idle(0);
    check("g_words", n_words - w0, 4);
    check("g_done", n_done - d0, 1);
    check("g_queue", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
